// File: rtl/enc32to5_stream.sv
// Purpose : streams the 5-bit index of every set bit of a 32-bit request vector, in priority order.
// Latency : 1 cycle from input handshake to first out_valid; then one index per cycle while out_ready=1.
// Backpr. : out_ready=0 holds out_idx/out_last/pend stable; in_ready is low while a vector is being emitted.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_vec/in_valid   - request vector and its valid; accepted when in_ready=1
//   in_ready          - high in IDLE only
//   flush             - synchronous abort; overrides any simultaneous handshake
//   out_idx/out_valid - current index and its valid; consumed when out_ready=1
//   out_ready         - consumer accept
//   out_last          - current index is the final set bit of the vector
//   bit_cnt           - popcount of the last accepted vector (held until next accept)
//   empty_pulse       - one-cycle pulse after accepting an all-zero vector
module enc32to5_stream #(
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_vec,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [4:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [5:0]  bit_cnt,
  output logic        empty_pulse
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]  state;
  logic [31:0] pend;

  // Index of the bit that goes out first, depending on HIGH_FIRST.
  function automatic logic [4:0] prio_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    if (HIGH_FIRST) begin
      // Ascending scan: the last hit is the highest set bit.
      for (int i = 0; i < 32; i++)
        if (v[i]) idx = 5'(i);
    end else begin
      // Descending scan: the last hit is the lowest set bit.
      for (int i = 31; i >= 0; i--)
        if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++)
      c = c + 6'(v[i]);
    return c;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic is_single(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  logic [31:0] pend_clr;
  logic        in_hs;
  logic        out_hs;

  always_comb begin
    pend_clr = pend & ~(32'd1 << out_idx);
    in_hs    = (state == ST_IDLE) && in_valid;
    out_hs   = (state == ST_EMIT) && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pend        <= 32'd0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_idx     <= 5'd0;
      out_last    <= 1'b0;
      bit_cnt     <= 6'd0;
      empty_pulse <= 1'b0;
    end else if (flush) begin
      // Abort wins over any handshake this cycle; bit_cnt is left alone.
      state       <= ST_IDLE;
      pend        <= 32'd0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      empty_pulse <= 1'b0;
    end else begin
      empty_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_hs) begin
            bit_cnt <= popcount(in_vec);
            if (in_vec != 32'd0) begin
              state     <= ST_EMIT;
              pend      <= in_vec;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_idx   <= prio_idx(in_vec);
              out_last  <= is_single(in_vec);
            end else begin
              empty_pulse <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_hs) begin
            if (out_last) begin
              // Return to IDLE; the idle cycle separates this vector from the next.
              state     <= ST_IDLE;
              pend      <= 32'd0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              pend     <= pend_clr;
              out_idx  <= prio_idx(pend_clr);
              out_last <= is_single(pend_clr);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          pend      <= 32'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/enc32to5_stream.md
Name: enc32to5_stream

Overview:
- Sequential counterpart to the team's 5-to-32 decoder: takes a 32-bit request vector (any number of bits set) and emits the 5-bit index of every set bit, one per handshake, in priority order.
- Sits between switch/event capture logic and index consumers on the Basys3 designs, such as display drivers and dec5to32-driven LED fan-out.
- Gives a loop-back path: a vector encoded here and fed through dec5to32 index by index rebuilds the original vector.

Parameters:
- HIGH_FIRST, 0: 0 = lowest set index emitted first; 1 = highest set index emitted first.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_vec  input  32  request vector; sampled on input handshake.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a new vector.
- flush  input  1  synchronous abort of the vector in progress.
- out_idx  output  5  encoded index of the current set bit.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_last  output  1  out_idx is the final set bit of the current vector.
- bit_cnt  output  6  number of set bits in the last accepted vector (0..32).
- empty_pulse  output  1  one-cycle pulse: the accepted vector was all zero.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, pend=0.
  - in_ready=1, out_valid=0, out_idx=0, out_last=0, bit_cnt=0, empty_pulse=0.
- Internal state: pending register pend[31:0]; FSM with states IDLE and EMIT.
- IDLE: in_ready=1, out_valid=0. Input handshake = in_valid & in_ready.
  - in_vec!=0:
    - pend<=in_vec; bit_cnt<=popcount(in_vec).
    - Next cycle: state=EMIT, in_ready=0, out_valid=1.
    - out_idx = priority index of in_vec; out_last=1 if popcount==1.
    - Latency from handshake to first out_valid: 1 cycle.
  - in_vec==0:
    - bit_cnt<=0; empty_pulse=1 for exactly the next cycle.
    - Stay in IDLE, in_ready stays 1, nothing emitted.
- Priority index:
  - HIGH_FIRST=0: lowest set bit of pend.
  - HIGH_FIRST=1: highest set bit of pend.
- EMIT: in_ready=0; in_valid is ignored.
  - Stall (out_ready=0): out_idx and out_last are held stable while out_valid=1; pend is unchanged.
  - Output handshake (out_valid & out_ready), more bits remaining: clear the emitted bit in pend. Next cycle out_valid stays 1 with the next index and updated out_last. Throughput is one index per cycle, no bubbles.
  - Output handshake with out_last=1: next cycle state=IDLE, out_valid=0, out_last=0, in_ready=1, pend=0. There is always one cycle between the last output handshake and the next possible input handshake.
- out_last=1 exactly when pend has a single bit set.
- Total output handshakes per vector = bit_cnt.
- bit_cnt holds its value until the next input handshake.
- flush=1 (synchronous, any state):
  - Next cycle: IDLE, pend=0, out_valid=0, out_last=0, in_ready=1.
  - bit_cnt is unchanged; empty_pulse=0.
  - flush has priority over a simultaneous input or output handshake; that handshake is discarded.
- out_ready asserted while out_valid=0 has no effect.
- Index 31 and index 0 are legal values. in_vec=32'hFFFF_FFFF emits 32 indices with no wrap.

Test Plan:
- Reset then idle: rst_n low mid-EMIT after in_vec=32'h0000_00F0 -> all outputs reach reset values immediately (asynchronously); after release, in_ready=1 and no stale out_valid.
- Basic, HIGH_FIRST=0: in_vec=32'h8000_0011, out_ready=1 -> bit_cnt=3; out_idx sequence 0,4,31 on three consecutive cycles, out_last only on 31; in_ready=1 one cycle later.
- HIGH_FIRST=1, same vector -> out_idx sequence 31,4,0; out_last on 0.
- Backpressure: in_vec=32'h0000_0006, out_ready=0 for 5 cycles -> out_idx=1 held stable with out_valid=1 throughout; then out_ready=1 -> 1 then 2, out_last on 2.
- Zero and full vectors: in_vec=0 -> empty_pulse for one cycle, bit_cnt=0, no out_valid; in_vec=32'hFFFF_FFFF -> bit_cnt=32, indices 0..31 in 32 cycles.
- Flush and round trip:
  - flush mid-stream of 32'h0000_0F00 after two outputs -> IDLE next cycle, no further out_valid.
  - Scoreboard: feeding each out_idx through dec5to32 (en=1) and ORing the results equals the accepted in_vec, over 1000 random vectors.
